mul_div_unit: RTL and testbench

- Iterative multiply/divide unit beside the single-cycle ALU. It takes the same SrcA/SrcB operands and owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles, plus single-cycle MTHI/MTLO.
- The controller stalls the PC while busy is high. HI/LO feed the writeback mux for MFHI/MFLO.

---
 rtl/mul_div_if.sv | 16 +
 rtl/mul_div_unit.sv | 131 +++++++++++++
 tb/tb_mul_div_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mul_div_if.sv
// Request/result bundle between the controller and the multiply/divide unit.
interface mul_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       MDOp;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output start, MDOp, SrcA, SrcB, input busy, done, HI, LO);
  modport slave  (input start, MDOp, SrcA, SrcB, output busy, done, HI, LO);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle on
// operand magnitudes, sign fix-up and HI/LO write in a final SIGN cycle.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic      CLK,
  input  logic      RST,
  mul_div_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_divz;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_arith;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_sh;
  logic               w_div_ok;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_arith  = bus.start && !bus.MDOp[2];
  assign w_signed = !bus.MDOp[0];
  assign w_a_neg  = w_signed && bus.SrcA[WIDTH-1];
  assign w_b_neg  = w_signed && bus.SrcB[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~bus.SrcA + 1'b1) : bus.SrcA;
  assign w_b_mag  = w_b_neg ? (~bus.SrcB + 1'b1) : bus.SrcB;

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; a zero divisor always
  // "succeeds", leaving quotient all-ones and remainder equal to the dividend.
  assign w_div_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_ok   = (w_div_sh >= {1'b0, r_opnd});
  assign w_div_diff = w_div_sh - {1'b0, r_opnd};
  assign w_div_next = {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_div_ok};

  assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quot = r_divz  ? '1 :
                  (r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0]);
  assign w_rem  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_divz   <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_arith) begin
            r_state  <= S_CALC;
            r_cnt    <= '0;
            r_is_div <= bus.MDOp[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_divz   <= bus.MDOp[1] && (bus.SrcB == '0);
            r_opnd   <= bus.MDOp[1] ? w_b_mag : w_a_mag;
            r_acc    <= {{WIDTH{1'b0}}, (bus.MDOp[1] ? w_a_mag : w_b_mag)};
          end else if (bus.start && bus.MDOp == OP_MTHI) begin
            r_hi <= bus.SrcA;
          end else if (bus.start && bus.MDOp == OP_MTLO) begin
            r_lo <= bus.SrcA;
          end
        end
        S_CALC: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH-1)) r_state <= S_SIGN;
        end
        S_SIGN: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: latency, results, ignored starts, reset.
module tb_mul_div_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic CLK;
  logic RST;
  int   vectors;
  int   miscompares;
  logic done_while_busy;

  mul_div_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK)
    if (bus.busy === 1'b1 && bus.done === 1'b1) done_while_busy = 1'b1;

  // Drive a one-cycle start; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    bus.start = 1'b1; bus.MDOp = op; bus.SrcA = a; bus.SrcB = b;
    @(negedge CLK);
    bus.start = 1'b0; bus.MDOp = 3'b111;
  endtask

  // Counts busy cycles, bounded; n==100 means the op never finished.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    RST = 1'b0; bus.start = 1'b0; bus.MDOp = 3'b111; bus.SrcA = '0; bus.SrcB = '0;
    repeat (2) @(negedge CLK);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.done); end
    vectors++; if (bus.HI !== 32'h0) begin miscompares++; $display("FAIL reset_hi got %h want 0", bus.HI); end
    vectors++; if (bus.LO !== 32'h0) begin miscompares++; $display("FAIL reset_lo got %h want 0", bus.LO); end
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_mult;
    int n;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_idle(n);
    vectors++; if (n !== 33) begin miscompares++; $display("FAIL mult_latency got %0d want 33", n); end
    vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL mult_done got %b want 1", bus.done); end
    vectors++; if (bus.HI !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_hi got %h want ffffffff", bus.HI); end
    vectors++; if (bus.LO !== 32'hFFFF_FFF1) begin miscompares++; $display("FAIL mult_lo got %h want fffffff1", bus.LO); end
    @(negedge CLK);
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL mult_done_pulse got %b want 0", bus.done); end
  endtask

  // MULTU result, then DIVU-by-zero started in the very cycle done is high.
  task automatic test_back_to_back;
    int n;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    vectors++; if (n !== 33) begin miscompares++; $display("FAIL multu_latency got %0d want 33", n); end
    vectors++; if (bus.HI !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL multu_hi got %h want fffffffe", bus.HI); end
    vectors++; if (bus.LO !== 32'h0000_0001) begin miscompares++; $display("FAIL multu_lo got %h want 00000001", bus.LO); end
    vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL multu_done got %b want 1", bus.done); end
    bus.start = 1'b1; bus.MDOp = OP_DIVU; bus.SrcA = 32'h1234; bus.SrcB = 32'h0;
    @(negedge CLK);
    bus.start = 1'b0; bus.MDOp = 3'b111; bus.SrcA = 32'hDEAD_BEEF; bus.SrcB = 32'd3;
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept busy got %b want 1", bus.busy); end
    wait_idle(n);
    vectors++; if (n !== 33) begin miscompares++; $display("FAIL divz_latency got %0d want 33", n); end
    vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL divz_done got %b want 1", bus.done); end
    vectors++; if (bus.LO !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL divz_lo got %h want ffffffff", bus.LO); end
    vectors++; if (bus.HI !== 32'h0000_1234) begin miscompares++; $display("FAIL divz_hi got %h want 00001234", bus.HI); end
  endtask

  task automatic test_div;
    int n;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    vectors++; if (n !== 33) begin miscompares++; $display("FAIL div_latency got %0d want 33", n); end
    vectors++; if (bus.LO !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_lo got %h want fffffffd", bus.LO); end
    vectors++; if (bus.HI !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_hi got %h want ffffffff", bus.HI); end
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h0);
    wait_idle(n);
    vectors++; if (bus.LO !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL sdivz_lo got %h want ffffffff", bus.LO); end
    vectors++; if (bus.HI !== 32'hFFFF_FFF9) begin miscompares++; $display("FAIL sdivz_hi got %h want fffffff9", bus.HI); end
  endtask

  task automatic test_mthi_mtlo;
    @(negedge CLK);
    bus.start = 1'b1; bus.MDOp = OP_MTHI; bus.SrcA = 32'hAAAA;
    @(negedge CLK);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mthi_busy got %b want 0", bus.busy); end
    bus.MDOp = OP_MTLO; bus.SrcA = 32'h5555;
    @(negedge CLK);
    bus.start = 1'b0; bus.MDOp = 3'b111;
    vectors++; if (bus.HI !== 32'hAAAA) begin miscompares++; $display("FAIL mthi_hi got %h want 0000aaaa", bus.HI); end
    vectors++; if (bus.LO !== 32'h5555) begin miscompares++; $display("FAIL mtlo_lo got %h want 00005555", bus.LO); end
    vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++; $display("FAIL mt_flags got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    // No-op codes must leave HI/LO alone.
    bus.start = 1'b1; bus.MDOp = 3'b110; bus.SrcA = 32'h1111;
    @(negedge CLK);
    bus.start = 1'b0; bus.MDOp = 3'b111;
    vectors++; if (bus.HI !== 32'hAAAA || bus.LO !== 32'h5555 || bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL noop got hi=%h lo=%h busy=%b want 0000aaaa 00005555 0", bus.HI, bus.LO, bus.busy); end
  endtask

  task automatic test_busy_ignore;
    int n;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge CLK);
    bus.start = 1'b1; bus.MDOp = OP_MULT; bus.SrcA = 32'd9; bus.SrcB = 32'd9;
    @(negedge CLK);
    bus.MDOp = OP_MTHI; bus.SrcA = 32'h7777;
    @(negedge CLK);
    bus.start = 1'b0; bus.MDOp = 3'b111;
    vectors++; if (bus.HI !== 32'hAAAA) begin miscompares++; $display("FAIL busy_mthi_hi got %h want 0000aaaa", bus.HI); end
    wait_idle(n);
    vectors++; if (n !== 33 - 11) begin miscompares++; $display("FAIL ignore_latency got %0d want 22", n); end
    vectors++; if (bus.LO !== 32'd14) begin miscompares++; $display("FAIL divu_lo got %h want 0000000e", bus.LO); end
    vectors++; if (bus.HI !== 32'd2) begin miscompares++; $display("FAIL divu_hi got %h want 00000002", bus.HI); end
    @(negedge CLK);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL ignore_no_second got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid;
    int n;
    logic saw_done;
    issue(OP_MULTU, 32'd3, 32'd4);
    repeat (14) @(negedge CLK);
    @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    vectors++; if (bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
      miscompares++; $display("FAIL rstmid_hilo got %h %h want 0 0", bus.HI, bus.LO); end
    @(negedge CLK);
    RST = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
    end
    vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL rstmid_quiet got activity=1 want 0"); end
    vectors++; if (bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
      miscompares++; $display("FAIL rstmid_after got %h %h want 0 0", bus.HI, bus.LO); end
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    vectors++; if (n !== 33) begin miscompares++; $display("FAIL ovf_latency got %0d want 33", n); end
    vectors++; if (bus.LO !== 32'h8000_0000) begin miscompares++; $display("FAIL ovf_lo got %h want 80000000", bus.LO); end
    vectors++; if (bus.HI !== 32'h0) begin miscompares++; $display("FAIL ovf_hi got %h want 00000000", bus.HI); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    done_while_busy = 1'b0;
    test_reset();
    test_mult();
    test_back_to_back();
    test_div();
    test_mthi_mtlo();
    test_busy_ignore();
    test_reset_mid();
    vectors++; if (done_while_busy !== 1'b0) begin
      miscompares++; $display("FAIL done_busy_overlap got 1 want 0"); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
